// File: rtl/npu_mem_sequencer.sv
// Bus master that runs one NPU job: streams the I/W/B images from external memory into the
// core windows, kicks the core, waits for completion, then streams OMEM back out.
module npu_mem_sequencer #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_i_base,
    input  logic [ADDR_W-1:0] src_w_base,
    input  logic [ADDR_W-1:0] src_b_base,
    input  logic [ADDR_W-1:0] dst_o_base,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        phase,
    output logic              m_req_valid,
    input  logic              m_req_ready,
    output logic              m_req_we,
    output logic [ADDR_W-1:0] m_req_addr,
    output logic [DATA_W-1:0] m_req_wdata,
    input  logic              m_rsp_valid,
    input  logic [DATA_W-1:0] m_rsp_data,
    input  logic              m_rsp_err,
    output logic              npu_start,
    input  logic              npu_done
);

    localparam logic [ADDR_W-1:0] NPU_IMEM_START = ADDR_W'(32'h0200_0000);
    localparam logic [ADDR_W-1:0] NPU_WMEM_START = ADDR_W'(32'h0200_3100);
    localparam logic [ADDR_W-1:0] NPU_BMEM_START = ADDR_W'(32'h0200_6200);
    localparam logic [ADDR_W-1:0] NPU_OMEM_START = ADDR_W'(32'h0200_6280);
    localparam logic [ADDR_W-1:0] ALIGN_MASK     = ~ADDR_W'(3);

    localparam int WIDX_W = 12;
    localparam logic [WIDX_W-1:0] LAST_IW = WIDX_W'(3135);
    localparam logic [WIDX_W-1:0] LAST_B  = WIDX_W'(31);
    localparam logic [WIDX_W-1:0] LAST_O  = WIDX_W'(2047);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_REQ,
        S_RD_WAIT,
        S_WR_REQ,
        S_KICK,
        S_WAIT_NPU,
        S_DONE,
        S_ERR
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          phase_q, phase_d;
    logic [WIDX_W-1:0]   widx_q, widx_d;
    logic                err_q, err_d;
    logic [ADDR_W-1:0]   src_i_q, src_i_d;
    logic [ADDR_W-1:0]   src_w_q, src_w_d;
    logic [ADDR_W-1:0]   src_b_q, src_b_d;
    logic [ADDR_W-1:0]   dst_o_q, dst_o_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic [ADDR_W-1:0]   word_off;
    logic [ADDR_W-1:0]   src_base;
    logic [ADDR_W-1:0]   dst_base;
    logic [WIDX_W-1:0]   last_idx;
    logic                last_word;

    // Per-phase source/destination windows; O reverses direction (core -> external memory).
    always_comb begin
        word_off = ADDR_W'({widx_q, 2'b00});
        src_base = src_i_q;
        dst_base = NPU_IMEM_START;
        last_idx = LAST_IW;
        case (phase_q)
            2'd0: begin
                src_base = src_i_q;
                dst_base = NPU_IMEM_START;
                last_idx = LAST_IW;
            end
            2'd1: begin
                src_base = src_w_q;
                dst_base = NPU_WMEM_START;
                last_idx = LAST_IW;
            end
            2'd2: begin
                src_base = src_b_q;
                dst_base = NPU_BMEM_START;
                last_idx = LAST_B;
            end
            default: begin
                src_base = NPU_OMEM_START;
                dst_base = dst_o_q;
                last_idx = LAST_O;
            end
        endcase
        last_word = (widx_q == last_idx);
    end

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        widx_d      = widx_q;
        err_d       = err_q;
        src_i_d     = src_i_q;
        src_w_d     = src_w_q;
        src_b_d     = src_b_q;
        dst_o_d     = dst_o_q;
        rdata_d     = rdata_q;
        m_req_valid = 1'b0;
        m_req_we    = 1'b0;
        m_req_addr  = '0;
        m_req_wdata = '0;
        npu_start   = 1'b0;
        done        = 1'b0;
        busy        = (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    src_i_d = src_i_base & ALIGN_MASK;
                    src_w_d = src_w_base & ALIGN_MASK;
                    src_b_d = src_b_base & ALIGN_MASK;
                    dst_o_d = dst_o_base & ALIGN_MASK;
                    err_d   = 1'b0;
                    phase_d = 2'd0;
                    widx_d  = '0;
                    state_d = S_RD_REQ;
                end
            end
            S_RD_REQ: begin
                m_req_valid = 1'b1;
                m_req_addr  = src_base + word_off;
                if (m_req_ready) begin
                    state_d = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                if (m_rsp_valid) begin
                    rdata_d = m_rsp_data;
                    if (m_rsp_err) begin
                        err_d   = 1'b1;
                        state_d = S_ERR;
                    end else begin
                        state_d = S_WR_REQ;
                    end
                end
            end
            S_WR_REQ: begin
                m_req_valid = 1'b1;
                m_req_we    = 1'b1;
                m_req_addr  = dst_base + word_off;
                m_req_wdata = rdata_q;
                if (m_req_ready) begin
                    if (!last_word) begin
                        widx_d  = widx_q + WIDX_W'(1);
                        state_d = S_RD_REQ;
                    end else if (phase_q == 2'd2) begin
                        state_d = S_KICK;
                    end else if (phase_q == 2'd3) begin
                        state_d = S_DONE;
                    end else begin
                        phase_d = phase_q + 2'd1;
                        widx_d  = '0;
                        state_d = S_RD_REQ;
                    end
                end
            end
            S_KICK: begin
                npu_start = 1'b1;
                state_d   = S_WAIT_NPU;
            end
            S_WAIT_NPU: begin
                if (npu_done) begin
                    phase_d = 2'd3;
                    widx_d  = '0;
                    state_d = S_RD_REQ;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            S_ERR: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign err   = err_q;
    assign phase = phase_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            phase_q <= 2'd0;
            widx_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            widx_q  <= widx_d;
            err_q   <= err_d;
        end
    end

    // Bases and read data are only observed through state-gated outputs, so they need no reset.
    always_ff @(posedge clk) begin
        src_i_q <= src_i_d;
        src_w_q <= src_w_d;
        src_b_q <= src_b_d;
        dst_o_q <= dst_o_d;
        rdata_q <= rdata_d;
    end

endmodule

// File: tb/tb_npu_mem_sequencer.sv
// Scoreboard bench for npu_mem_sequencer: a job-level reference model queues the expected bus
// transactions, a memory/NPU responder drives the DUT, and a monitor checks what the DUT presents.
module tb_npu_mem_sequencer;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam logic [31:0] IMEM = 32'h0200_0000;
    localparam logic [31:0] WMEM = 32'h0200_3100;
    localparam logic [31:0] BMEM = 32'h0200_6200;
    localparam logic [31:0] OMEM = 32'h0200_6280;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] src_i_base, src_w_base, src_b_base, dst_o_base;
    logic              busy, done, err;
    logic [1:0]        phase;
    logic              m_req_valid, m_req_ready, m_req_we;
    logic [ADDR_W-1:0] m_req_addr;
    logic [DATA_W-1:0] m_req_wdata;
    logic              m_rsp_valid;
    logic [DATA_W-1:0] m_rsp_data;
    logic              m_rsp_err;
    logic              npu_start, npu_done;

    always #5 clk = ~clk;

    npu_mem_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .start(start),
        .src_i_base(src_i_base), .src_w_base(src_w_base),
        .src_b_base(src_b_base), .dst_o_base(dst_o_base),
        .busy(busy), .done(done), .err(err), .phase(phase),
        .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_we(m_req_we),
        .m_req_addr(m_req_addr), .m_req_wdata(m_req_wdata),
        .m_rsp_valid(m_rsp_valid), .m_rsp_data(m_rsp_data), .m_rsp_err(m_rsp_err),
        .npu_start(npu_start), .npu_done(npu_done)
    );

    // kind: 0 read, 1 write, 2 npu kick, 3 job end
    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [31:0] data;
        logic        err;
    } ev_t;

    ev_t         exp_q[$];
    logic [31:0] mem[logic [31:0]];
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          rd_total = 0;
    int          err_at = 0;
    int          o_rd_cnt = 0;
    int          npu_cnt = 0;
    int          last_kick_cyc = 0;
    int          kick_to_rd = -1;
    bit          after_kick = 1'b0;
    bit          bp_job = 1'b0;
    bit          early_mode = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    function automatic logic [31:0] memread(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return (a * 32'h9E37_79B1) ^ 32'hA5C3_0F1E ^ (a >> 9);
    endfunction

    task automatic push_ev(input int kind, input logic [31:0] a, input logic [31:0] d, input logic e);
        ev_t ev;
        ev.kind = kind;
        ev.addr = a;
        ev.data = d;
        ev.err  = e;
        exp_q.push_back(ev);
    endtask

    // Whole-job reference: every word is a read of src+4k followed by a write of that word to dst+4k.
    task automatic push_job(input logic [31:0] si, input logic [31:0] sw, input logic [31:0] sb,
                            input logic [31:0] dob, input int err_rd);
        logic [31:0] src[4];
        logic [31:0] dst[4];
        int          n[4];
        int          rd;
        src = '{si & 32'hFFFF_FFFC, sw & 32'hFFFF_FFFC, sb & 32'hFFFF_FFFC, OMEM};
        dst = '{IMEM, WMEM, BMEM, dob & 32'hFFFF_FFFC};
        n   = '{32'h3100 / 4, 32'h3100 / 4, 32'h80 / 4, 32'h2000 / 4};
        rd  = 0;
        for (int p = 0; p < 4; p++) begin
            for (int k = 0; k < n[p]; k++) begin
                rd++;
                push_ev(0, src[p] + 32'(4 * k), 32'h0, 1'b0);
                if (rd == err_rd) begin
                    push_ev(3, 32'h0, 32'h0, 1'b1);
                    return;
                end
                push_ev(1, dst[p] + 32'(4 * k), memread(src[p] + 32'(4 * k)), 1'b0);
            end
            if (p == 2) push_ev(2, 32'h0, 32'h0, 1'b0);
        end
        push_ev(3, 32'h0, 32'h0, 1'b0);
    endtask

    // Bus slave: external memory plus NPU windows, optional backpressure and late/stray responses.
    bit          r_hs, r_we, pend, delivered, bp_active;
    logic [31:0] r_addr, r_wd, p_addr;
    logic [1:0]  r_ph;
    logic        p_err;
    int          dly;
    initial begin
        m_req_ready = 1'b0;
        m_rsp_valid = 1'b0;
        m_rsp_data  = '0;
        m_rsp_err   = 1'b0;
        pend        = 1'b0;
        dly         = 0;
        forever begin
            @(negedge clk);
            r_hs   = m_req_valid && m_req_ready && !rst;
            r_we   = m_req_we;
            r_addr = m_req_addr;
            r_wd   = m_req_wdata;
            r_ph   = phase;
            @(posedge clk);
            #1;
            m_rsp_valid = 1'b0;
            m_rsp_err   = 1'b0;
            delivered   = 1'b0;
            if (rst) pend = 1'b0;
            if (!busy) o_rd_cnt = 0;
            bp_active = bp_job && ((phase == 2'd2) || (phase == 2'd3 && o_rd_cnt >= 1 && o_rd_cnt < 1024));
            if (r_hs && r_we) begin
                mem[r_addr] = r_wd;
            end else if (r_hs) begin
                rd_total++;
                pend   = 1'b1;
                p_addr = r_addr;
                p_err  = (rd_total == err_at);
                dly    = bp_active ? int'($urandom_range(1, 5)) : 0;
                if (r_ph == 2'd3) o_rd_cnt++;
            end
            if (pend) begin
                if (dly == 0) begin
                    m_rsp_valid = 1'b1;
                    m_rsp_data  = memread(p_addr);
                    m_rsp_err   = p_err;
                    pend        = 1'b0;
                    delivered   = 1'b1;
                end else begin
                    dly--;
                end
            end
            if (bp_active && !delivered && !pend && $urandom_range(0, 7) == 0) begin
                m_rsp_valid = 1'b1;
                m_rsp_data  = $urandom;
                m_rsp_err   = 1'($urandom_range(0, 1));
            end
            m_req_ready = bp_active ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // NPU model: completion 10 cycles after the kick, or held high throughout in early mode.
    initial begin
        npu_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (early_mode) begin
                npu_done = 1'b1;
            end else if (npu_start) begin
                npu_cnt  = 10;
                npu_done = 1'b0;
            end else if (npu_cnt > 0) begin
                npu_cnt--;
                npu_done = (npu_cnt == 0);
            end else begin
                npu_done = 1'b0;
            end
        end
    end

    // Monitor: pops the scoreboard on every accepted request, kick and job end.
    bit          stall_prev = 1'b0;
    logic [65:0] stall_fields;
    bit          has_ev;
    ev_t         got, want;
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev)
                    check("req_hold", 128'({m_req_valid, m_req_we, m_req_addr, m_req_wdata}), 128'(stall_fields));
                stall_prev   = m_req_valid && !m_req_ready;
                stall_fields = {m_req_valid, m_req_we, m_req_addr, m_req_wdata};
                has_ev = 1'b1;
                got.addr = '0;
                got.data = '0;
                got.err  = 1'b0;
                if (m_req_valid && m_req_ready) begin
                    got.kind = m_req_we ? 1 : 0;
                    got.addr = m_req_addr;
                    got.data = m_req_we ? m_req_wdata : 32'h0;
                    if (!m_req_we && after_kick) begin
                        kick_to_rd = cyc - last_kick_cyc;
                        after_kick = 1'b0;
                    end
                end else if (npu_start) begin
                    got.kind      = 2;
                    last_kick_cyc = cyc;
                    after_kick    = 1'b1;
                end else if (done) begin
                    got.kind = 3;
                    got.err  = err;
                end else begin
                    has_ev = 1'b0;
                end
                if (has_ev) begin
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_event: got kind %0d addr 0x%h data 0x%h, expected none",
                                 got.kind, got.addr, got.data);
                    end else begin
                        want = exp_q.pop_front();
                        check("bus_event", {32'(got.kind), got.addr, got.data, 31'b0, got.err},
                              {32'(want.kind), want.addr, want.data, 31'b0, want.err});
                    end
                end
            end
        end
    end

    initial begin
        repeat (95000) @(posedge clk);
        $display("FAIL watchdog: cycle budget exhausted, %0d vectors, %0d miscompares", vectors, miscompares);
        $fatal(1, "watchdog expired");
    end

    task automatic start_job(input logic [31:0] si, input logic [31:0] sw, input logic [31:0] sb,
                             input logic [31:0] dob, input int err_rd);
        push_job(si, sw, sb, dob, err_rd);
        @(posedge clk);
        #1;
        start = 1'b1;
        src_i_base = si;
        src_w_base = sw;
        src_b_base = sb;
        dst_o_base = dob;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("start_valid", 128'(m_req_valid), 128'(1));
        check("start_busy", 128'(busy), 128'(1));
        check("start_err_clear", 128'(err), 128'(0));
        check("start_phase", 128'(phase), 128'(0));
        check("start_addr", 128'(m_req_addr), 128'(si & 32'hFFFF_FFFC));
    endtask

    task automatic wait_done(input int budget, input bit noise);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(posedge clk);
            #1;
            if (noise && busy && $urandom_range(0, 199) == 0) begin
                start      = 1'b1;
                src_i_base = $urandom;
                src_w_base = $urandom;
                src_b_base = $urandom;
                dst_o_base = $urandom;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        check("job_end_seen", 128'(seen), 128'(1));
    endtask

    initial begin
        bit found;
        rst = 1'b1;
        start = 1'b0;
        src_i_base = '0;
        src_w_base = '0;
        src_b_base = '0;
        dst_o_base = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_done", 128'(done), 128'(0));
        check("rst_err", 128'(err), 128'(0));
        check("rst_phase", 128'(phase), 128'(0));
        check("rst_req", 128'({m_req_valid, m_req_we, m_req_addr, m_req_wdata}), 128'(0));
        check("rst_npu_start", 128'(npu_start), 128'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Full job on a zero-wait bus, misaligned B base, stray start pulses while busy.
        start_job(32'h0000_4000, 32'h0001_0000, 32'h0010_0003, 32'h0020_0000, 0);
        wait_done(30000, 1'b1);
        check("jobA_queue_drained", 128'(exp_q.size()), 128'(0));

        // Error on the 5th W-phase read.
        err_at = rd_total + 3136 + 5;
        start_job(32'h0000_4000, 32'h0001_0000, 32'h0010_0000, 32'h0020_0000, 3136 + 5);
        wait_done(12000, 1'b0);
        err_at = 0;
        @(negedge clk);
        check("err_sticky", 128'(err), 128'(1));
        check("err_idle", 128'(busy), 128'(0));
        check("jobB_queue_drained", 128'(exp_q.size()), 128'(0));

        // Reset while a W-phase write is presented.
        start_job(32'h0000_4000, 32'h0001_0000, 32'h0010_0000, 32'h0020_0000, 0);
        found = 1'b0;
        for (int c = 0; c < 12000; c++) begin
            @(negedge clk);
            if (phase == 2'd1 && m_req_valid && m_req_we) begin
                found = 1'b1;
                break;
            end
        end
        check("reach_w_write", 128'(found), 128'(1));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("midrst_busy", 128'(busy), 128'(0));
        check("midrst_err_phase", 128'({err, phase}), 128'(0));
        check("midrst_req", 128'({m_req_valid, m_req_we, m_req_addr, m_req_wdata}), 128'(0));
        check("midrst_npu_start", 128'(npu_start), 128'(0));
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("midrst_quiet", 128'({done, m_req_valid}), 128'(0));
        end

        // Restart: early npu_done held high, backpressure through B and the first O words.
        early_mode = 1'b1;
        bp_job     = 1'b1;
        start_job(32'h0000_4000, 32'h0001_0000, 32'h0010_0000, 32'h0030_0000, 0);
        wait_done(45000, 1'b0);
        check("jobD_queue_drained", 128'(exp_q.size()), 128'(0));
        check("early_kick_to_oread", 128'(kick_to_rd), 128'(2));
        for (int k = 0; k < 2048; k++)
            check("o_image", 128'(memread(32'h0030_0000 + 32'(4 * k))),
                  128'(memread(32'h0020_0000 + 32'(4 * k))));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
